// File: rtl/timer_pkg.sv
// Shared types and helpers for the BCD mm:ss timer.
// Holds the timer state enum and BCD digit limits.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } t_timer_state;

    localparam logic [3:0] DIGIT_MAX    = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    function automatic logic is_valid_bcd_digit(
        input logic [3:0] d,
        input logic [3:0] max_val
    );
        return d <= max_val;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit that wraps at MAX_VAL in either direction.
// co flags that this step wraps the digit and must ripple on.
module bcd_digit_counter #(
    parameter logic [3:0] MAX_VAL = 4'd9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       up,
    input  logic       ld,
    input  logic [3:0] ld_val,
    output logic [3:0] q,
    output logic       co
);

    // Digit register: load beats step, wrap at the digit limits.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 4'd0;
        end else if (ld) begin
            q <= ld_val;
        end else if (ena) begin
            if (up) begin
                q <= (q == MAX_VAL) ? 4'd0 : q + 4'd1;
            end else begin
                q <= (q == 4'd0) ? MAX_VAL : q - 4'd1;
            end
        end
    end

    assign co = ena && (up ? (q == MAX_VAL) : (q == 4'd0));

endmodule

// File: rtl/bcd_mmss_timer.sv
// BCD minutes:seconds up/down timer stepped by a 1 s strobe.
// Optional low-time warning built when TIMER_WARN_EN is defined.
module bcd_mmss_timer
    import timer_pkg::*;
#(
    parameter int          MIN_DIGITS = 2,
    parameter logic [7:0]  WARN_SS    = 8'h10,
    localparam int         ND         = MIN_DIGITS + 2,
    localparam int         CW         = 4 * ND
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          start,
    input  logic          stop,
    input  logic          mode_up,
    output logic [CW-1:0] count_out,
    output logic          running,
    output logic          tc,
    output logic          expired,
    output logic          load_err,
    output logic          warn
);

    t_timer_state state;
    t_timer_state state_nxt;

    logic          mode_q;
    logic          ld_valid;
    logic          ld_ok;
    logic          step;
    logic          start_acc;
    logic          start_term;
    logic          hit_term;
    logic [ND-1:0] ena;
    logic [ND-1:0] co;
    logic [ND-1:0] at_zero;
    logic [ND-1:0] at_max;
    logic [ND-1:0] pre_zero;
    logic [ND-1:0] pre_max;

    for (genvar i = 0; i < ND; i++) begin : g_dig
        localparam logic [3:0] MAXV = (i == 1) ? SEC_TENS_MAX : DIGIT_MAX;

        bcd_digit_counter #(
            .MAX_VAL (MAXV)
        ) u_dig (
            .clk    (clk),
            .reset  (reset),
            .ena    (ena[i]),
            .up     (mode_q),
            .ld     (ld_ok),
            .ld_val (load_value[4*i +: 4]),
            .q      (count_out[4*i +: 4]),
            .co     (co[i])
        );

        assign at_zero[i] = (count_out[4*i +: 4] == 4'd0);
        assign at_max[i]  = (count_out[4*i +: 4] == MAXV);

        // Seconds-ones is the only digit that moves on the final step.
        if (i == 0) begin : g_lsd
            assign ena[i]      = step;
            assign pre_zero[i] = (count_out[3:0] == 4'd1);
            assign pre_max[i]  = (count_out[3:0] == 4'd8);
        end else begin : g_msd
            assign ena[i]      = co[i-1];
            assign pre_zero[i] = at_zero[i];
            assign pre_max[i]  = at_max[i];
        end
    end

    // Every nibble must be decimal and seconds-tens must stay below 6.
    always_comb begin
        ld_valid = 1'b1;
        for (int i = 0; i < ND; i++) begin
            ld_valid &= is_valid_bcd_digit(
                load_value[4*i +: 4],
                (i == 1) ? SEC_TENS_MAX : DIGIT_MAX);
        end
    end

    // Command decode in priority order: load, stop, start, tick.
    always_comb begin
        ld_ok      = load && ld_valid;
        step       = !load && !stop && tick && (state == RUN);
        start_acc  = !load && !stop && start &&
                     ((state == IDLE) || (state == PAUSE));
        start_term = start_acc && (mode_up ? &at_max : &at_zero);
        hit_term   = step && (mode_q ? &pre_max : &pre_zero);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a ripple out of the top digit also ends the run.
    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE, PAUSE: begin
                    if (start_acc) begin
                        state_nxt = start_term ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_nxt = PAUSE;
                    end else if (hit_term || co[ND-1]) begin
                        state_nxt = DONE;
                    end
                end
                DONE: state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State-decoded outputs.
    always_comb begin
        running = (state == RUN);
        expired = (state == DONE);
    end

    // Direction latch and one-cycle event pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q   <= 1'b0;
            tc       <= 1'b0;
            load_err <= 1'b0;
        end else begin
            if (start_acc) begin
                mode_q <= mode_up;
            end
            tc       <= hit_term || start_term;
            load_err <= load && !ld_valid;
        end
    end

`ifdef TIMER_WARN_EN
    // Low-time warning, derived from the registered count and state.
    always_comb begin
        warn = ((state == RUN) || (state == PAUSE)) && !mode_q &&
               (count_out[CW-1:8] == '0) &&
               (count_out[7:0] <= WARN_SS);
    end
`else
    // Warning disabled; the threshold only feeds a constant zero.
    assign warn = &{1'b0, WARN_SS};
`endif

endmodule

// File: tb/tb_bcd_mmss_timer.sv
// Self-checking bench for bcd_mmss_timer: directed plan then random run.
// Reference model tracks time as plain seconds.
module tb_bcd_mmss_timer;

    localparam int         MD   = 2;
    localparam int         CW   = 4 * (MD + 2);
    localparam logic [7:0] WSS  = 8'h10;
    localparam int         MAXS = (10 ** MD) * 60 - 1;
    localparam int         M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic          clk = 1'b0;
    logic          reset, tick, load, start, stop, mode_up;
    logic [CW-1:0] load_value;
    logic [CW-1:0] count_out;
    logic          running, tc, expired, load_err, warn;

    int n_cmp = 0;
    int n_bad = 0;

    int m_secs = 0;
    int m_st   = M_IDLE;
    bit m_up   = 1'b0;
    bit m_tc   = 1'b0;
    bit m_err  = 1'b0;

    always #5 clk = ~clk;

    bcd_mmss_timer #(
        .MIN_DIGITS (MD),
        .WARN_SS    (WSS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .stop       (stop),
        .mode_up    (mode_up),
        .count_out  (count_out),
        .running    (running),
        .tc         (tc),
        .expired    (expired),
        .load_err   (load_err),
        .warn       (warn)
    );

    function automatic logic [CW-1:0] to_bcd(input int secs);
        logic [CW-1:0] v;
        int mm, ss, p;
        mm = secs / 60;
        ss = secs % 60;
        v = '0;
        v[3:0] = 4'(ss % 10);
        v[7:4] = 4'(ss / 10);
        p = 1;
        for (int i = 0; i < MD; i++) begin
            v[8 + 4*i +: 4] = 4'((mm / p) % 10);
            p = p * 10;
        end
        return v;
    endfunction

    function automatic bit bcd_ok(input logic [CW-1:0] v);
        for (int i = 0; i < MD + 2; i++) begin
            if (int'(v[4*i +: 4]) > ((i == 1) ? 5 : 9)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int bcd_secs(input logic [CW-1:0] v);
        int mm, p;
        mm = 0;
        p = 1;
        for (int i = 0; i < MD; i++) begin
            mm = mm + int'(v[8 + 4*i +: 4]) * p;
            p = p * 10;
        end
        return mm * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic bit m_term();
        return m_up ? (m_secs == MAXS) : (m_secs == 0);
    endfunction

    function automatic bit m_warn();
`ifdef TIMER_WARN_EN
        int thr;
        thr = int'(WSS[7:4]) * 10 + int'(WSS[3:0]);
        return ((m_st == M_RUN) || (m_st == M_PAUSE)) && !m_up &&
               (m_secs < 60) && (m_secs <= thr);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit rst, input bit ld,
                         input logic [CW-1:0] lv, input bit st,
                         input bit sp, input bit up, input bit tk);
        int cur;
        cur = m_st;
        m_tc = 1'b0;
        m_err = 1'b0;
        if (rst) begin
            m_secs = 0;
            m_st = M_IDLE;
            m_up = 1'b0;
        end else if (ld) begin
            m_st = M_IDLE;
            if (bcd_ok(lv)) m_secs = bcd_secs(lv);
            else m_err = 1'b1;
        end else if (sp) begin
            if (cur == M_RUN) m_st = M_PAUSE;
        end else begin
            if (st && ((cur == M_IDLE) || (cur == M_PAUSE))) begin
                m_up = up;
                if (m_term()) begin
                    m_st = M_DONE;
                    m_tc = 1'b1;
                end else begin
                    m_st = M_RUN;
                end
            end
            if (tk && (cur == M_RUN)) begin
                m_secs = m_secs + (m_up ? 1 : -1);
                if (m_term()) begin
                    m_st = M_DONE;
                    m_tc = 1'b1;
                end
            end
        end
    endtask

    task automatic cyc(input bit rst, input bit ld,
                       input logic [CW-1:0] lv, input bit st,
                       input bit sp, input bit up, input bit tk);
        @(negedge clk);
        reset = rst;
        load = ld;
        load_value = lv;
        start = st;
        stop = sp;
        mode_up = up;
        tick = tk;
        @(posedge clk);
        model(rst, ld, lv, st, sp, up, tk);
        #1;
        chk("count_out", 32'(count_out), 32'(to_bcd(m_secs)));
        chk("running", 32'(running), 32'(m_st == M_RUN));
        chk("expired", 32'(expired), 32'(m_st == M_DONE));
        chk("tc", 32'(tc), 32'(m_tc));
        chk("load_err", 32'(load_err), 32'(m_err));
        chk("warn", 32'(warn), 32'(m_warn()));
    endtask

    task automatic nop();
        cyc(0, 0, '0, 0, 0, 0, 0);
    endtask

    task automatic ld(input logic [CW-1:0] v);
        cyc(0, 1, v, 0, 0, 0, 0);
    endtask

    task automatic go(input bit up);
        cyc(0, 0, '0, 1, 0, up, 0);
    endtask

    task automatic tk();
        cyc(0, 0, '0, 0, 0, 0, 1);
    endtask

    initial begin
        logic [CW-1:0] lv;
        int r;

        cyc(1, 0, '0, 0, 0, 0, 0);
        chk("rst_count", 32'(count_out), 32'h0);
        chk("rst_flags", 32'({running, tc, expired, load_err, warn}), 32'h0);

        ld(16'h0203);
        go(0);
        for (int i = 0; i < 4; i++) tk();
        chk("down_0159", 32'(count_out), 32'h0159);

        ld(16'h0002);
        go(0);
        tk();
        tk();
        chk("down_zero_tc", 32'({count_out, tc, expired, running}),
            32'({16'h0000, 3'b110}));
        nop();
        tk();
        go(0);
        chk("done_hold", 32'({count_out, expired}), 32'({16'h0000, 1'b1}));

        ld(16'h9958);
        go(1);
        tk();
        chk("up_term", 32'({count_out, tc, expired}), 32'({16'h9959, 2'b11}));
        ld(16'h0059);
        go(1);
        tk();
        chk("up_carry", 32'(count_out), 32'h0100);

        ld(16'h0130);
        go(0);
        tk();
        cyc(0, 0, '0, 1, 1, 0, 0);
        tk();
        tk();
        chk("pause_hold", 32'({count_out, running}), 32'({16'h0129, 1'b0}));
        go(0);
        tk();
        chk("resume", 32'(count_out), 32'h0128);

        ld(16'h0A00);
        chk("bad_min", 32'({count_out, load_err}), 32'({16'h0128, 1'b1}));
        ld(16'h0060);
        chk("bad_sec", 32'(load_err), 32'h1);
        go(0);
        tk();
        ld(16'h0345);
        chk("ld_run", 32'({count_out, running}), 32'({16'h0345, 1'b0}));
        go(0);
        tk();
        cyc(1, 0, '0, 0, 0, 0, 1);
        chk("rst_run", 32'({count_out, running}), 32'h0);

        ld(16'h0012);
        go(0);
        tk();
        tk();
`ifdef TIMER_WARN_EN
        chk("warn_on", 32'({count_out, warn}), 32'({16'h0010, 1'b1}));
`else
        chk("warn_off", 32'({count_out, warn}), 32'({16'h0010, 1'b0}));
`endif
        for (int i = 0; i < 10; i++) tk();
        chk("warn_done", 32'({count_out, warn, expired}),
            32'({16'h0000, 2'b01}));

        for (int n = 0; n < 4000; n++) begin
            r = int'($urandom_range(0, 3));
            case (r)
                0: lv = CW'($urandom);
                1: lv = to_bcd(MAXS - int'($urandom_range(0, 5)));
                2: lv = to_bcd(int'($urandom_range(0, 5)));
                default: lv = to_bcd(int'($urandom_range(0, MAXS)));
            endcase
            cyc($urandom_range(0, 299) == 0,
                $urandom_range(0, 24) == 0,
                lv,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 15) == 0,
                1'($urandom),
                $urandom_range(0, 1) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_mmss_timer.md
Name: bcd_mmss_timer

Overview:
Parametrised BCD minutes:seconds timer that counts down or up once per external 1 s strobe. It supports a runtime load value, start/stop (pause) control and sticky expiry, and generalises the fixed 3-digit countdown to MIN_DIGITS minute digits. The block sits between the game-control FSM (start/stop/load) and the 7-segment BCD decoders (count_out nibbles).

Parameters:
MIN_DIGITS, 2, number of BCD minute digits (1..4); count width CW = 4*(MIN_DIGITS+2)
WARN_SS, 8'h10, BCD seconds threshold for the low-time warning (used only with TIMER_WARN_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tick  in  1  one-cycle 1 s strobe from the prescaler
load  in  1  load load_value, clear expiry, enter IDLE
load_value  in  CW  BCD preset; [3:0] sec ones, [7:4] sec tens, upper nibbles minutes (LS first)
start  in  1  begin/resume counting
stop  in  1  pause counting
mode_up  in  1  1 = count up toward max, 0 = count down toward 0; sampled on accepted start
count_out  out  CW  current BCD value
running  out  1  high in RUN state
tc  out  1  one-cycle pulse when terminal value is reached
expired  out  1  sticky; high in DONE
load_err  out  1  one-cycle pulse when load_value is rejected
warn  out  1  low-time warning (see Optional Feature)

Behaviour:
- Reset (sync, active-high): count_out=0, state IDLE, mode latch=down, running=0, tc=0, expired=0, load_err=0, warn=0.
- States: IDLE, RUN, PAUSE, DONE (enum in package).
- Priority per cycle: reset > load > stop > start > tick.
- load, any state: if load_value is valid BCD (each nibble ≤9, sec tens ≤5), count ← load_value, state → IDLE, expired ← 0. If invalid, count is unchanged, state → IDLE, load_err pulses in the next cycle.
- start in IDLE/PAUSE: latch mode_up, state → RUN. Ignored in RUN and DONE; DONE leaves only via load/reset.
- start while count is already terminal (0 for down, all-9s:59 for up): state → DONE, tc pulses the next cycle, count unchanged.
- stop in RUN: → PAUSE. start and stop together: stop wins. load and start together: load wins, start dropped.
- tick in RUN: count steps by 1 s; registered value visible the cycle after tick (latency 1). tick outside RUN is ignored.
- Down step: sec ones 0→9 borrows; sec tens 0→5 borrows; minute digits 0→9 cascade borrow.
- Up step: sec ones 9→0 carries; sec tens 5→0 carries; minute digits 9→0 cascade.
- Terminal values: down = all zeros; up = minutes all 9, seconds 59.
- A step that lands on terminal: tc=1 for exactly one cycle, coincident with the new count_out. expired=1 from the same cycle; state → DONE.
- No wrap past terminal: count holds in DONE.
- running = (state==RUN). mode_up changes outside an accepted start have no effect.

Optional Feature:
- Macro TIMER_WARN_EN.
- Defined: warn=1 while state is RUN or PAUSE, the latched mode is down, all minute digits are 0, and seconds ≤ WARN_SS (direct BCD compare). warn is registered alongside count_out and is 0 in IDLE/DONE.
- Undefined: warn is tied 0; no compare logic is built; the port list is unchanged.

Decomposition:
- Package timer_pkg: state enum t_timer_state; constants DIGIT_MAX=4'd9, SEC_TENS_MAX=4'd5; function is_valid_bcd_digit.
- Sub-module bcd_digit_counter (parameter MAX_VAL):
  - inputs: clk, reset, ena, up, ld, ld_val;
  - outputs: q, carry/borrow out.
  - Instantiated MIN_DIGITS+2 times: MAX_VAL=9 except sec tens (MAX_VAL=5).

Test Plan:
- MIN_DIGITS=2; load 16'h0203, start (down), 4 ticks → 0202, 0201, 0200, 0159; no tc.
- load 16'h0002, start, 2 ticks → 0001, then 0000 with tc pulse 1 cycle and expired=1, running=0; further ticks/start → no change until load.
- load 16'h9958, mode_up=1, start, 1 tick → 9959 with tc and expired; load 16'h0059 up, 1 tick → 0100.
- RUN; stop and start asserted the same cycle → PAUSE; ticks ignored; start → RUN, counting resumes from the held value.
- load 16'h0A00 or 16'h0060 → load_err pulse, count unchanged, state IDLE; load mid-RUN → new value, IDLE, expired cleared; reset mid-RUN → all outputs 0 the next cycle.
- TIMER_WARN_EN, WARN_SS=8'h10: count down from 0012 → warn rises when count_out=0010, stays high to 0001, 0 in DONE; with macro off, warn stays 0 throughout.
